// File: rtl/reduction_ctrl_pkg.sv
// reduction_ctrl_pkg: shared definitions for the reduction-tree controller.
//   - switch command encodings (passed through to the adder switches untouched)
//   - controller FSM state encoding
//   - cfg_w(): per-switch context width, {add_en, cmd[2:0], sel[SEL_IN-1:0]}
package reduction_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NA      = 3'b000,
    CMD_FWD     = 3'b001,
    CMD_ADD     = 3'b010,
    CMD_VN_L    = 3'b011,
    CMD_VN_R    = 3'b100,
    CMD_VN_BOTH = 3'b101
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int cfg_w(input int sel_in);
    return 4 + sel_in;
  endfunction

endpackage

// File: rtl/reduction_ctrl_fifo.sv
// ctx_fifo: 2-entry context FIFO.
//   clk, rst    : clock, synchronous active-low reset
//   push, ready : push handshake; ready is registered (!full of the next count)
//   din         : context pushed on push && ready
//   pop         : drop the head entry (ignored when empty)
//   head, empty : current head entry, FIFO empty flag
module ctx_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  output logic         ready,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, count_nx;
  logic              push_fire, pop_fire;

  assign push_fire = push && ready;
  assign pop_fire  = pop && (count != 2'd0);
  assign count_nx  = count + 2'(push_fire) - 2'(pop_fire);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      ready  <= 1'b0;
    end else begin
      count <= count_nx;
      // ready looks one cycle ahead so it can be a plain flop
      ready <= (count_nx != 2'd2);
      if (push_fire) wr_ptr <= ~wr_ptr;
      if (pop_fire)  rd_ptr <= ~rd_ptr;
    end
  end

  // storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/reduction_ctrl.sv
// reduction_ctrl: sequences contexts through a LEVELS-deep adder-switch tree.
// A launch streams i_len leaf vectors (RUN); the valid wavefront then walks
// down one level per cycle (DRAIN) and o_done pulses as it leaves the last
// level. Each level's switch configuration is reloaded just as the new
// wavefront reaches it, so the tail of the previous stream is undisturbed.
//   clk, rst                          : clock, synchronous active-low reset
//   i_cfg_valid/o_cfg_ready/i_cfg_data: context push into 2-entry FIFO
//   i_start, i_len                    : launch head context for i_len vectors
//   o_in_ready                        : leaf data accepted this cycle
//   o_sw_valid/add_en/cmd/sel         : per-switch drive, switch s at level s/SW_PER_LVL
//   o_busy, o_done, o_err             : status (done = 1-cycle pulse, err sticky)
// Optional build macro REDUCTION_CTRL_PERF_EN adds o_run_cycles (cycles in
// RUN/DRAIN, saturating) and o_ctx_count (completed contexts, wrapping).
module reduction_ctrl
  import reduction_ctrl_pkg::*;
#(
  parameter  int LEVELS     = 3,
  parameter  int SW_PER_LVL = 4,
  parameter  int SEL_IN     = 2,
  parameter  int CNT_W      = 16,
  localparam int NUM_SW     = LEVELS * SW_PER_LVL,
  localparam int CFG_W      = cfg_w(SEL_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [NUM_SW*CFG_W-1:0] i_cfg_data,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_len,
  output logic                    o_in_ready,
  output logic [NUM_SW-1:0]       o_sw_valid,
  output logic [NUM_SW-1:0]       o_sw_add_en,
  output logic [3*NUM_SW-1:0]     o_sw_cmd,
  output logic [SEL_IN*NUM_SW-1:0] o_sw_sel,
`ifdef REDUCTION_CTRL_PERF_EN
  output logic [31:0]             o_run_cycles,
  output logic [15:0]             o_ctx_count,
`endif
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int LVL_W = SW_PER_LVL * CFG_W;
  localparam int CTX_W = NUM_SW * CFG_W;

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CTX_W-1:0]   head;
  logic               empty;
  logic               start_ok, launch;
  logic               run, busy, done;
  logic               err;
  logic [LEVELS-1:0]  vld_pipe, ld_pipe;
  logic [LEVELS-1:1]  vld_dly, ld_dly;
  logic [CTX_W-1:0]   cfg_q;

  // head stays in the FIFO until o_done, so every level reads it directly
  ctx_fifo #(.W(CTX_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_cfg_valid),
    .ready (o_cfg_ready),
    .din   (i_cfg_data),
    .pop   (done),
    .head  (head),
    .empty (empty)
  );

  assign start_ok = i_start && (state == IDLE) && !empty;
  assign launch   = start_ok && (i_len != '0);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE:    if (start_ok) cnt <= i_len;
        // cnt counts remaining RUN cycles, then the LEVELS drain cycles down to 0
        RUN:     cnt <= (cnt == CNT_W'(1)) ? CNT_W'(LEVELS - 1) : cnt - 1'b1;
        DRAIN:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    unique case (state)
      // zero-length launch goes straight to DRAIN with cnt = 0: done next cycle
      IDLE:    if (start_ok) state_nx = (i_len == '0) ? DRAIN : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nx = DRAIN;
      DRAIN:   if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    run  = (state == RUN);
    busy = (state != IDLE);
    done = (state == DRAIN) && (cnt == '0);
  end

  // ---- wavefront: valids and config loads walk one level per cycle ----
  assign vld_pipe = {vld_dly, run};
  assign ld_pipe  = {ld_dly, launch};

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_dly <= '0;
      ld_dly  <= '0;
      cfg_q   <= '0;
      err     <= 1'b0;
    end else begin
      vld_dly <= vld_pipe[LEVELS-2:0];
      ld_dly  <= ld_pipe[LEVELS-2:0];
      for (int l = 0; l < LEVELS; l++)
        if (ld_pipe[l]) cfg_q[l*LVL_W +: LVL_W] <= head[l*LVL_W +: LVL_W];
      if (i_start && !start_ok) err <= 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    assign o_sw_valid[s]                = vld_pipe[s / SW_PER_LVL];
    assign o_sw_add_en[s]               = cfg_q[s*CFG_W + CFG_W - 1];
    assign o_sw_cmd[3*s +: 3]           = cfg_q[s*CFG_W + SEL_IN +: 3];
    assign o_sw_sel[s*SEL_IN +: SEL_IN] = cfg_q[s*CFG_W +: SEL_IN];
  end

  assign o_in_ready = run;
  assign o_busy     = busy;
  assign o_done     = done;
  assign o_err      = err;

`ifdef REDUCTION_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_run_cycles <= '0;
      o_ctx_count  <= '0;
    end else begin
      if (busy && (o_run_cycles != '1)) o_run_cycles <= o_run_cycles + 1'b1;
      if (done) o_ctx_count <= o_ctx_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reduction_ctrl.sv
// tb_reduction_ctrl: directed + randomized checks of reduction_ctrl against a
// cycle-offset model (expected values derived from the launch cycle k).
module tb_reduction_ctrl;
  import reduction_ctrl_pkg::*;

  localparam int LEVELS = 3;
  localparam int SPL    = 4;
  localparam int SEL    = 2;
  localparam int CNT    = 16;
  localparam int NSW    = LEVELS * SPL;
  localparam int CW     = 4 + SEL;
  localparam int CFGW   = NSW * CW;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [CFGW-1:0]  i_cfg_data;
  logic             i_start;
  logic [CNT-1:0]   i_len;
  logic             o_in_ready;
  logic [NSW-1:0]   o_sw_valid, o_sw_add_en;
  logic [3*NSW-1:0] o_sw_cmd;
  logic [SEL*NSW-1:0] o_sw_sel;
  logic             o_busy, o_done, o_err;
`ifdef REDUCTION_CTRL_PERF_EN
  logic [31:0]      o_run_cycles;
  logic [15:0]      o_ctx_count;
`endif

  reduction_ctrl #(.LEVELS(LEVELS), .SW_PER_LVL(SPL), .SEL_IN(SEL), .CNT_W(CNT)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_data(i_cfg_data),
    .i_start(i_start), .i_len(i_len), .o_in_ready(o_in_ready),
    .o_sw_valid(o_sw_valid), .o_sw_add_en(o_sw_add_en), .o_sw_cmd(o_sw_cmd), .o_sw_sel(o_sw_sel),
`ifdef REDUCTION_CTRL_PERF_EN
    .o_run_cycles(o_run_cycles), .o_ctx_count(o_ctx_count),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic [CFGW-1:0] mq[$];
  logic [CFGW-1:0] cur_cfg;
  bit              err_m;
  int              run_m, ctx_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CFGW-1:0] rand_ctx();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[CFGW-1:0];
  endfunction

  // reassemble the per-switch drive into the pushed context layout
  function automatic logic [CFGW-1:0] obs_cfg();
    logic [CFGW-1:0] v;
    for (int s = 0; s < NSW; s++)
      v[s*CW +: CW] = {o_sw_add_en[s], o_sw_cmd[3*s +: 3], o_sw_sel[s*SEL +: SEL]};
    return v;
  endfunction

  task automatic chk_perf(input string tag);
`ifdef REDUCTION_CTRL_PERF_EN
    chk({tag, "_run_cycles"}, o_run_cycles, run_m);
    chk({tag, "_ctx_count"}, o_ctx_count, ctx_m);
`else
    if (tag.len() == 0) $display("note: empty perf tag");
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_ready"}, o_cfg_ready, 0);
    chk({tag, "_in_ready"}, o_in_ready, 0);
    chk({tag, "_valid"}, o_sw_valid, 0);
    chk({tag, "_cfg"}, obs_cfg(), 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic push(input logic [CFGW-1:0] ctx);
    chk("push_ready", o_cfg_ready, 1);
    i_cfg_valid = 1'b1;
    i_cfg_data  = ctx;
    step();
    i_cfg_valid = 1'b0;
    mq.push_back(ctx);
  endtask

  // launch the head context in the current cycle (k) and follow it to IDLE
  task automatic run(input int len, input bit poke);
    logic [CFGW-1:0] nxt;
    logic [NSW-1:0]  ev;
    logic [CFGW-1:0] ec;
    int last;
    nxt = mq[0];
    chk("busy_at_k", o_busy, 0);
    i_start = 1'b1;
    i_len   = CNT'(len);
    step();
    i_start = 1'b0;
    last = (len == 0) ? 1 : len + LEVELS;
    for (int t = 1; t <= last; t++) begin
      ev = '0;
      ec = cur_cfg;
      for (int s = 0; s < NSW; s++) begin
        int l;
        l = s / SPL;
        ev[s] = (len > 0) && (t >= 1 + l) && (t <= len + l);
        if (len > 0 && t >= 1 + l) ec[s*CW +: CW] = nxt[s*CW +: CW];
      end
      chk("in_ready", o_in_ready, (len > 0) && (t <= len));
      chk("sw_valid", o_sw_valid, ev);
      chk("sw_cfg", obs_cfg(), ec);
      chk("done", o_done, t == last);
      chk("busy", o_busy, 1);
      chk("err", o_err, err_m);
      chk("cfg_ready", o_cfg_ready, mq.size() < 2);
      if (poke && t == 2) i_start = 1'b1;
      step();
      if (poke && t == 2) begin
        i_start = 1'b0;
        err_m = 1'b1;
      end
    end
    void'(mq.pop_front());
    if (len > 0) cur_cfg = nxt;
    run_m += last;
    ctx_m++;
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("idle_valid", o_sw_valid, 0);
    chk("idle_cfg_ready", o_cfg_ready, mq.size() < 2);
    chk("idle_cfg", obs_cfg(), cur_cfg);
    chk_perf("run");
  endtask

  initial begin
    int len;
    bit poke;
    rst = 1'b0; i_cfg_valid = 1'b0; i_cfg_data = '0; i_start = 1'b0; i_len = '0;
    cur_cfg = '0; err_m = 1'b0; run_m = 0; ctx_m = 0;

    // reset state
    step(); step();
    chk_all_zero("reset");
    chk_perf("reset");
    rst = 1'b1;
    step();
    chk("ready_after_reset", o_cfg_ready, 1);

    // single context, len 5: in_ready k+1..k+5, level2 k+3..k+7, done k+8
    push(rand_ctx());
    run(5, 1'b0);

    // two contexts: FIFO full, then back-to-back launch at k+9
    push(rand_ctx());
    push(rand_ctx());
    chk("full_ready", o_cfg_ready, 0);
    run(5, 1'b0);
    run(3, 1'b0);

    // zero-length launch
    push(rand_ctx());
    run(0, 1'b0);

    // start while busy is ignored and raises err
    push(rand_ctx());
    run(4, 1'b1);

    // start with empty FIFO
    i_start = 1'b1; i_len = CNT'(3);
    step();
    i_start = 1'b0;
    err_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("empty_start_busy", o_busy, 0);
      chk("empty_start_err", o_err, 1);
      step();
    end

    // reset in cycle k+3 of a len-5 run with a second context queued
    push(rand_ctx());
    push(rand_ctx());
    i_start = 1'b1; i_len = CNT'(5);
    step();
    i_start = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk_all_zero("midrun_reset");
    mq.delete();
    cur_cfg = '0; err_m = 1'b0; run_m = 0; ctx_m = 0;
    chk_perf("midrun_reset");
    rst = 1'b1;
    step();
    chk("ready_after_midrun", o_cfg_ready, 1);
    // FIFO must have been emptied: a start is refused
    i_start = 1'b1; i_len = CNT'(2);
    step();
    i_start = 1'b0;
    chk("discard_busy", o_busy, 0);
    chk("discard_err", o_err, 1);
    err_m = 1'b1;

    // randomized launches
    for (int i = 0; i < 10; i++) begin
      if (mq.size() == 0 || (mq.size() < 2 && $urandom_range(0, 1) == 1)) push(rand_ctx());
      len  = $urandom_range(0, 6);
      poke = (len > 0) && ($urandom_range(0, 3) == 0);
      run(len, poke);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
